// File: rtl/rv32_pkg.sv
// Basic RV32 data types shared across the core and its bus adapters.
package rv32;

  // Native machine word of the core.
  typedef logic [31:0] word_t;

endpackage

// File: rtl/saratoga_pkg.sv
// Saratoga platform-wide bus definitions.
package saratoga;

  // Default byte-address width of the AXI space.
  localparam int DEFAULT_AXI_ADDR_WIDTH = 32;

  // AXI response encoding.
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite master: turns single-word core read/write requests into one
// AXI4-Lite transaction each and returns the result for one DONE cycle.
// A request withdrawn mid-flight still finishes on the bus, silently.
module axi_lite_master
  import saratoga::*;
  import rv32::*;
#(
  parameter int AXI_ADDR_WIDTH = DEFAULT_AXI_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  // core side
  input  logic                      rd_en,
  input  logic                      wr_en,
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  input  word_t                     wr_data,
  input  logic [3:0]                wr_strobe,
  output word_t                     rd_data,
  output logic                      access_fault,
  output logic                      busy,
  // AXI write channels
  output logic [AXI_ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]                awprot,
  output logic                      awvalid,
  input  logic                      awready,
  output word_t                     wdata,
  output logic [3:0]                wstrb,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
  // AXI read channels
  output logic [AXI_ADDR_WIDTH-1:0] araddr,
  output logic [2:0]                arprot,
  output logic                      arvalid,
  input  logic                      arready,
  input  word_t                     rdata,
  input  logic [1:0]                rresp,
  input  logic                      rvalid,
  output logic                      rready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e                    state_r, state_n;
  logic                      orphan_r, orphan_n;
  logic                      awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
  logic                      fault_n;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_n, araddr_n;
  word_t                     wdata_n, rd_data_n;
  logic [3:0]                wstrb_n;
  logic                      withdrawn_s, orphan_hit_s, aw_done_s, w_done_s;

  // Unprivileged, secure, data accesses only.
  assign awprot = 3'b000;
  assign arprot = 3'b000;

  // Core dropped both enables: whatever is in flight has no consumer any more.
  assign withdrawn_s  = ~rd_en & ~wr_en;
  assign orphan_hit_s = orphan_r | withdrawn_s;

  // A write channel is finished once its valid has been retired by a handshake.
  assign aw_done_s = ~awvalid | awready;
  assign w_done_s  = ~wvalid | wready;

  assign busy = ~rst & (((state_r != IDLE) & (state_r != DONE)) |
                        ((state_r == IDLE) & (rd_en | wr_en)));

  // Next-state and next-register-value logic for the transaction FSM.
  always_comb begin
    state_n   = state_r;
    orphan_n  = orphan_r;
    awvalid_n = awvalid;
    wvalid_n  = wvalid;
    bready_n  = bready;
    arvalid_n = arvalid;
    rready_n  = rready;
    awaddr_n  = awaddr;
    wdata_n   = wdata;
    wstrb_n   = wstrb;
    araddr_n  = araddr;
    rd_data_n = rd_data;
    fault_n   = 1'b0;

    case (state_r)
      IDLE: begin
        orphan_n = 1'b0;
        if (rd_en && wr_en) begin
          state_n = DONE;
          fault_n = 1'b1;
        end else if (wr_en) begin
          state_n   = WRITE;
          awvalid_n = 1'b1;
          wvalid_n  = 1'b1;
          awaddr_n  = addr;
          wdata_n   = wr_data;
          wstrb_n   = wr_strobe;
        end else if (rd_en) begin
          state_n   = RD_ADDR;
          arvalid_n = 1'b1;
          araddr_n  = addr;
        end else begin
          state_n = IDLE;
        end
      end

      WRITE: begin
        orphan_n = orphan_hit_s;
        if (awvalid && awready) begin
          awvalid_n = 1'b0;
        end else begin
          awvalid_n = awvalid;
        end
        if (wvalid && wready) begin
          wvalid_n = 1'b0;
        end else begin
          wvalid_n = wvalid;
        end
        if (aw_done_s && w_done_s) begin
          state_n  = WR_RESP;
          bready_n = 1'b1;
        end else begin
          state_n = WRITE;
        end
      end

      WR_RESP: begin
        orphan_n = orphan_hit_s;
        if (bvalid) begin
          bready_n = 1'b0;
          if (orphan_hit_s) begin
            state_n  = IDLE;
            orphan_n = 1'b0;
          end else begin
            state_n = DONE;
            fault_n = (bresp != OKAY);
          end
        end else begin
          state_n = WR_RESP;
        end
      end

      RD_ADDR: begin
        orphan_n = orphan_hit_s;
        if (arready) begin
          state_n   = RD_DATA;
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
        end else begin
          state_n = RD_ADDR;
        end
      end

      RD_DATA: begin
        orphan_n = orphan_hit_s;
        if (rvalid) begin
          rready_n = 1'b0;
          if (orphan_hit_s) begin
            state_n  = IDLE;
            orphan_n = 1'b0;
          end else begin
            state_n   = DONE;
            rd_data_n = rdata;
            fault_n   = (rresp != OKAY);
          end
        end else begin
          state_n = RD_DATA;
        end
      end

      DONE: begin
        state_n  = IDLE;
        orphan_n = 1'b0;
      end

      default: begin
        state_n   = IDLE;
        orphan_n  = 1'b0;
        awvalid_n = 1'b0;
        wvalid_n  = 1'b0;
        bready_n  = 1'b0;
        arvalid_n = 1'b0;
        rready_n  = 1'b0;
      end
    endcase
  end

  // FSM state and withdrawn-request flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      orphan_r <= 1'b0;
    end else begin
      state_r  <= state_n;
      orphan_r <= orphan_n;
    end
  end

  // Registered AXI channel outputs, so no ready feeds a valid combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      awaddr  <= '0;
      wdata   <= 32'h0000_0000;
      wstrb   <= 4'h0;
      araddr  <= '0;
    end else begin
      awvalid <= awvalid_n;
      wvalid  <= wvalid_n;
      bready  <= bready_n;
      arvalid <= arvalid_n;
      rready  <= rready_n;
      awaddr  <= awaddr_n;
      wdata   <= wdata_n;
      wstrb   <= wstrb_n;
      araddr  <= araddr_n;
    end
  end

  // Result presented to the core; the fault bit is only ever high in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data      <= 32'h0000_0000;
      access_fault <= 1'b0;
    end else begin
      rd_data      <= rd_data_n;
      access_fault <= fault_n;
    end
  end

endmodule
